// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, operand-select encodings and default widths
package alu_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_REG_CNT = 32;
  localparam int DEF_IMM_W   = 16;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10} alu_op_e;
  typedef enum logic {SRC_A_REG = 1'b0, SRC_A_PC = 1'b1} src_a_e;
  typedef enum logic [1:0] {SRC_B_REG = 2'b00, SRC_B_IMM = 2'b01, SRC_B_ONE = 2'b10, SRC_B_RSVD = 2'b11} src_b_e;
  typedef enum logic {EXT_ZERO = 1'b0, EXT_SIGN = 1'b1} ext_e;
endpackage

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register array with write-port forwarding and hard-wired r0
module reg_file
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_CNT = DEF_REG_CNT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic              wr_live;
  always_comb begin
    wr_live = wr_en && wr_addr != '0;
    rd1 = rs1_addr == '0 ? '0 : wr_live && wr_addr == rs1_addr ? wr_data : regs_q[rs1_addr];
    rd2 = rs2_addr == '0 ? '0 : wr_live && wr_addr == rs2_addr ? wr_data : regs_q[rs2_addr];
  end
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '{default: '0};
    else if (wr_live) regs_q[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register read, immediate extension and latched ALU operands A/B/store_data
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_CNT = DEF_REG_CNT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int IMM_W   = DEF_IMM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] pc,
  input  logic              sig_ext_op,
  input  logic              sig_src_a,
  input  logic [1:0]        sig_src_b,
  input  logic              sig_latch_ab,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] store_data
);
  logic [DATA_W-1:0] rd1, rd2, ext, a_d, b_d, a_q, b_q, sd_q;
  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_CNT(REG_CNT)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd1     (rd1),
    .rd2     (rd2)
  );
  always_comb begin
    ext = {{(DATA_W-IMM_W){sig_ext_op == EXT_SIGN && imm[IMM_W-1]}}, imm};
    a_d = sig_src_a == SRC_A_PC ? pc : rd1;
    b_d = sig_src_b == SRC_B_REG ? rd2 :
          sig_src_b == SRC_B_IMM ? ext :
          sig_src_b == SRC_B_ONE ? DATA_W'(1) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      sd_q <= '0;
    end else if (sig_latch_ab) begin
      a_q  <= a_d;
      b_q  <= b_d;
      sd_q <= rd2;
    end
  end
  assign A          = a_q;
  assign B          = b_q;
  assign store_data = sd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed plan plus random traffic checked against a register-array model
module tb_alu_operand_stage;
  logic        clock = 0, reset, sig_ext_op, sig_src_a, sig_latch_ab, wr_en;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr;
  logic [15:0] imm;
  logic [1:0]  sig_src_b;
  logic [31:0] pc, wr_data, A, B, store_data;
  logic [31:0] m [32];
  logic [31:0] exp_a = 0, exp_b = 0, exp_sd = 0;
  int          checks = 0, errors = 0;
  string       tag;

  alu_operand_stage dut (
    .clock(clock), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .imm(imm), .pc(pc), .sig_ext_op(sig_ext_op), .sig_src_a(sig_src_a),
    .sig_src_b(sig_src_b), .sig_latch_ab(sig_latch_ab), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .A(A), .B(B), .store_data(store_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (wr_en && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  task automatic check(input string what, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s %s observed=%h expected=%h", tag, what, obs, expv);
    end
  endtask

  task automatic tick();
    int simm;
    if (reset) begin
      foreach (m[i]) m[i] = 0;
      exp_a = 0; exp_b = 0; exp_sd = 0;
    end else begin
      if (sig_latch_ab) begin
        simm = sig_ext_op ? int'(signed'(imm)) : int'(imm);
        exp_a  = sig_src_a ? pc : rd(rs1_addr);
        exp_b  = sig_src_b == 0 ? rd(rs2_addr) : sig_src_b == 1 ? 32'(simm) : sig_src_b == 2 ? 1 : 0;
        exp_sd = rd(rs2_addr);
      end
      if (wr_en && wr_addr != 0) m[wr_addr] = wr_data;
    end
    @(posedge clock);
    #1;
    check("A", A, exp_a);
    check("B", B, exp_b);
    check("store_data", store_data, exp_sd);
  endtask

  task automatic idle();
    reset = 0; wr_en = 0; sig_latch_ab = 0; sig_src_a = 0; sig_src_b = 0; sig_ext_op = 0;
    rs1_addr = 0; rs2_addr = 0; wr_addr = 0; wr_data = 0; imm = 0; pc = 0;
  endtask

  initial begin
    idle();
    reset = 1; tag = "reset"; tick();
    idle(); rs1_addr = 3; rs2_addr = 7; sig_latch_ab = 1; tag = "read_after_reset"; tick();
    check("A_zero", A, 32'h0);
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h0000_00FF; tag = "write_r5"; tick();
    idle(); rs1_addr = 5; sig_src_b = 1; imm = 16'hFFFE; sig_ext_op = 1; sig_latch_ab = 1; tag = "sext"; tick();
    check("A_r5", A, 32'h0000_00FF);
    check("B_sext", B, 32'hFFFF_FFFE);
    sig_ext_op = 0; tag = "zext"; tick();
    check("B_zext", B, 32'h0000_FFFE);
    idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h1234_5678; rs1_addr = 9; rs2_addr = 9; sig_latch_ab = 1; tag = "fwd"; tick();
    check("A_fwd", A, 32'h1234_5678);
    check("SD_fwd", store_data, 32'h1234_5678);
    idle(); rs2_addr = 9; sig_latch_ab = 1; tag = "r9_later"; tick();
    check("B_r9", B, 32'h1234_5678);
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; sig_latch_ab = 1; tag = "r0_write"; tick();
    check("A_r0", A, 32'h0);
    idle(); sig_latch_ab = 1; tag = "r0_read"; tick();
    idle(); rs1_addr = 5; sig_latch_ab = 1; tag = "latch_r5"; tick();
    idle(); wr_en = 1; wr_addr = 5; wr_data = 7; rs1_addr = 5; tag = "hold"; tick();
    check("A_hold", A, 32'h0000_00FF);
    idle(); pc = 32'h40; sig_src_a = 1; sig_src_b = 2; sig_latch_ab = 1; tag = "pc_one"; tick();
    check("A_pc", A, 32'h40);
    check("B_one", B, 32'h1);
    sig_src_b = 3; tag = "rsvd"; tick();
    check("B_rsvd", B, 32'h0);
    idle(); reset = 1; wr_en = 1; wr_addr = 4; wr_data = 11; sig_latch_ab = 1; pc = 32'h99; sig_src_a = 1; tag = "reset_mid"; tick();
    idle(); rs1_addr = 4; sig_latch_ab = 1; tag = "r4_after_reset"; tick();
    check("A_r4", A, 32'h0);
    for (int n = 0; n < 300; n++) begin
      reset        = $urandom_range(0, 59) == 0;
      wr_en        = $urandom_range(0, 2) != 0;
      wr_addr      = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
      wr_data      = $urandom;
      rs1_addr     = 5'($urandom_range(0, 3) == 0 ? wr_addr : $urandom);
      rs2_addr     = 5'($urandom_range(0, 3) == 0 ? wr_addr : $urandom);
      imm          = 16'($urandom);
      pc           = $urandom;
      sig_ext_op   = 1'($urandom);
      sig_src_a    = 1'($urandom);
      sig_src_b    = 2'($urandom);
      sig_latch_ab = $urandom_range(0, 3) != 0;
      tag = "random";
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
